// File: rtl/if_id_buffer.sv
// Fetch-to-decode elastic buffer: in-order FIFO of {pc, instr} pairs with
// valid/ready handshakes on both sides and a flush for taken branches.
// The head entry drives decode directly. When empty, pc_o reads 0 and
// instr_o reads NOP.
module if_id_buffer #(
  parameter int unsigned       XLEN  = 32,
  parameter int unsigned       DEPTH = 2,
  parameter logic [XLEN-1:0]   NOP   = 32'h0000_0013,
  localparam int unsigned      CW    = $clog2(DEPTH + 1),
  localparam int unsigned      PW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  input  logic            ready_i,
  input  logic            flush_i,
  output logic [CW-1:0]   count_o
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic            push, pop;

  // Handshake flags; ready/valid come from the registered count only, so
  // there is no combinational path from ready_i to ready_o.
  assign ready_o = (count_q != FULL_COUNT);
  assign valid_o = (count_q != '0);
  assign push    = valid_i & ready_o & ~flush_i;
  assign pop     = valid_o & ready_i & ~flush_i;
  assign count_o = count_q;

  // Head entry drives decode; an empty buffer presents a bubble.
  assign pc_o    = valid_o ? pc_mem_q[rd_ptr_q]    : '0;
  assign instr_o = valid_o ? instr_mem_q[rd_ptr_q] : NOP;

  // Next-state for occupancy and pointers; flush dominates push and pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // DEPTH is a power of two, so the natural PW-bit overflow wraps
      // DEPTH-1 -> 0.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy and pointer registers, cleared immediately by async reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage: written on push, never cleared on pop.
  always_ff @(posedge clk_i) begin
    // NOTE: storage has no reset on purpose; count and pointers alone decide
    // validity, and the outputs are masked while empty.
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pc_i;
      instr_mem_q[wr_ptr_q] <= instr_i;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed vector table, hand-written
// multi-cycle sequences and random traffic against a queue-based model.
module tb_if_id_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, ready_i, flush_i;
  logic [31:0] pc_i, instr_i;
  logic        ready_o, valid_o;
  logic [31:0] pc_o, instr_o;
  logic [1:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t model_q[$];

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ready;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_count;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[8];

  if_id_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .pc_i    (pc_i),
    .instr_i (instr_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .pc_o    (pc_o),
    .instr_o (instr_o),
    .ready_i (ready_i),
    .flush_i (flush_i),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the queue model.
  task automatic check_model(input string tag);
    int unsigned n;
    n = model_q.size();
    check({tag, " valid_o"}, 32'(valid_o), 32'(n != 0));
    check({tag, " ready_o"}, 32'(ready_o), 32'(n != DEPTH));
    check({tag, " count_o"}, 32'(count_o), n);
    check({tag, " pc_o"},    pc_o,    (n != 0) ? model_q[0].pc    : 32'h0);
    check({tag, " instr_o"}, instr_o, (n != 0) ? model_q[0].instr : NOP);
  endtask

  // Drive one cycle, advance the model by the handshake rules, and leave
  // time 1 unit past the edge so outputs can be sampled.
  task automatic cycle(input logic v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic r,
                       input logic f);
    bit do_push, do_pop;
    valid_i = v; pc_i = pc; instr_i = instr; ready_i = r; flush_i = f;
    do_push = v && (model_q.size() < DEPTH) && !f;
    do_pop  = r && (model_q.size() > 0) && !f;
    @(posedge clk_i);
    if (f) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: pc, instr: instr});
    end
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; pc_i = '0; instr_i = '0;
    model_q.delete();
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    // Directed vectors; expected values are post-edge outputs.
    //           v  pc        instr         r  f   ev epc       einstr        ec er
    vecs[0] = '{1, 32'h0,  32'h00A00093, 0, 0,  1, 32'h0,  32'h00A00093, 1, 1};
    vecs[1] = '{1, 32'h4,  32'h00400113, 0, 0,  1, 32'h0,  32'h00A00093, 2, 0};
    vecs[2] = '{1, 32'h8,  32'h00800193, 0, 0,  1, 32'h0,  32'h00A00093, 2, 0};
    vecs[3] = '{0, 32'h8,  32'h00800193, 1, 0,  1, 32'h4,  32'h00400113, 1, 1};
    vecs[4] = '{0, 32'h0,  32'h0,        1, 0,  0, 32'h0,  NOP,          0, 1};
    vecs[5] = '{1, 32'hC,  32'h00C00213, 0, 0,  1, 32'hC,  32'h00C00213, 1, 1};
    vecs[6] = '{1, 32'h14, 32'h01400293, 0, 0,  1, 32'hC,  32'h00C00213, 2, 0};
    vecs[7] = '{1, 32'h10, 32'h01000313, 1, 1,  0, 32'h0,  NOP,          0, 1};

    do_reset();
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset instr_o", instr_o, NOP);
    check("reset pc_o",    pc_o, 32'h0);
    check("reset ready_o", 32'(ready_o), 32'd1);
    check("reset count_o", 32'(count_o), 32'd0);

    foreach (vecs[i]) begin
      cycle(vecs[i].valid, vecs[i].pc, vecs[i].instr, vecs[i].ready,
            vecs[i].flush);
      check($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d pc_o", i),    pc_o,    vecs[i].exp_pc);
      check($sformatf("vec%0d instr_o", i), instr_o, vecs[i].exp_instr);
      check($sformatf("vec%0d count_o", i), 32'(count_o), vecs[i].exp_count);
      check($sformatf("vec%0d ready_o", i), 32'(ready_o), 32'(vecs[i].exp_ready));
    end

    // After the flush, the dropped pc 0x10 must never appear.
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("post-flush valid_o", 32'(valid_o), 32'd0);
    check_model("post-flush");

    // Streaming: head lags input by one cycle, occupancy holds at 1.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'(4 * i), 32'h00000093 | (32'(i) << 20), 1'b1, 1'b0);
      check($sformatf("stream%0d pc_o", i),    pc_o, 32'(4 * i));
      check($sformatf("stream%0d count_o", i), 32'(count_o), 32'd1);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("stream drain count_o", 32'(count_o), 32'd0);

    // Async reset mid-cycle with one entry buffered.
    cycle(1'b1, 32'h40, 32'h04000393, 1'b0, 1'b0);
    valid_i = 1'b0;
    check("pre-async count_o", 32'(count_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    model_q.delete();
    check("async valid_o", 32'(valid_o), 32'd0);
    check("async instr_o", instr_o, NOP);
    check("async pc_o",    pc_o, 32'h0);
    check("async count_o", 32'(count_o), 32'd0);
    check("async ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i); #3 rst_i = 1'b0;
    @(posedge clk_i); #1;
    cycle(1'b1, 32'h80, 32'h08000413, 1'b0, 1'b0);
    check_model("post-reset push");

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            $urandom(),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
